// File: rtl/rtc_param_editor.sv
// Push-button BCD time/date editor: snapshots the RTC read-back values, lets the user step
// each field with auto-repeat, and emits a one-cycle Listo strobe when the user commits.
module rtc_param_editor #(
    parameter int REP_DLY  = 50_000_000,
    parameter int REP_RATE = 10_000_000
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       En_Config,
    input  logic       Btn_Up,
    input  logic       Btn_Down,
    input  logic       Btn_Right,
    input  logic       Btn_Left,
    input  logic       Btn_Guardar,
    input  logic       doce_24,
    input  logic [7:0] Seg_In,
    input  logic [7:0] Min_In,
    input  logic [7:0] Hora_In,
    input  logic [7:0] Dia_In,
    input  logic [7:0] Mes_In,
    input  logic [7:0] Ano_In,
    output logic [7:0] clk_seg,
    output logic [7:0] clk_min,
    output logic [7:0] clk_hora,
    output logic [7:0] Dia,
    output logic [7:0] Mes,
    output logic [7:0] Ano,
    output logic [2:0] Campo,
    output logic       Editando,
    output logic       Listo
);
    typedef enum logic [1:0] {IDLE, LOAD, EDIT, COMMIT} state_t;
    state_t state_q, state_d;

    function automatic logic [6:0] b2i(input logic [7:0] b);
        return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
    endfunction

    function automatic logic [7:0] i2b(input logic [6:0] v);
        logic [3:0] tens, ones;
        tens = 4'(v / 7'd10);
        ones = 4'(v % 7'd10);
        return {tens, ones};
    endfunction

    function automatic logic [7:0] step_bcd(input logic [7:0] v, input logic up,
                                            input logic [6:0] lo, input logic [6:0] hi);
        logic [6:0] n;
        n = b2i(v);
        if (up) n = (n >= hi) ? lo : n + 7'd1;
        else    n = (n <= lo || n > hi) ? hi : n - 7'd1;
        return i2b(n);
    endfunction

    // 12h hora: [5] = PM, [4:0] = BCD 01..12; the PM flag flips across 11 <-> 12
    function automatic logic [7:0] step12(input logic [5:0] v, input logic up);
        logic [6:0] h;
        logic       pm;
        logic [7:0] b;
        h  = b2i({3'b000, v[4:0]});
        pm = v[5];
        if (up) begin
            if (h == 7'd11)      begin h = 7'd12; pm = ~pm; end
            else if (h >= 7'd12) h = 7'd1;
            else                 h = h + 7'd1;
        end else begin
            if (h == 7'd12)      begin h = 7'd11; pm = ~pm; end
            else if (h <= 7'd1)  h = 7'd12;
            else                 h = h - 7'd1;
        end
        b = i2b(h);
        return {2'b01, pm, b[4:0]};
    endfunction

    function automatic logic [7:0] to12(input logic [7:0] h24);
        logic [6:0] h;
        h = b2i(h24);
        if (h == 7'd0)  return 8'h52;
        if (h < 7'd12)  return 8'h40 | i2b(h);
        if (h == 7'd12) return 8'h72;
        return 8'h60 | i2b(h - 7'd12);
    endfunction

    function automatic logic [7:0] to24(input logic [5:0] h12);
        logic [6:0] h;
        h = b2i({3'b000, h12[4:0]});
        if (!h12[5]) return (h == 7'd12) ? 8'h00 : i2b(h);
        return (h == 7'd12) ? 8'h12 : i2b(h + 7'd12);
    endfunction

    function automatic logic [6:0] maxday(input logic [7:0] m, input logic [7:0] a);
        logic [6:0] mb;
        mb = b2i(m);
        if (mb == 7'd2) return (b2i(a) % 7'd4 == 7'd0) ? 7'd29 : 7'd28;
        if (mb == 7'd4 || mb == 7'd6 || mb == 7'd9 || mb == 7'd11) return 7'd30;
        return 7'd31;
    endfunction

    // buttons: {guardar, up, down, right, left}
    logic [4:0] btn, btn_q, edge_q;
    logic       en_q, en_edge_q, mode_q;
    assign btn = {Btn_Guardar, Btn_Up, Btn_Down, Btn_Right, Btn_Left};

    // during reset the history follows the inputs so a held button yields no edge afterwards
    always_ff @(posedge CLK) begin
        btn_q <= btn;
        en_q  <= En_Config;
        if (Reset) begin
            edge_q    <= '0;
            en_edge_q <= 1'b0;
        end else begin
            edge_q    <= btn & ~btn_q;
            en_edge_q <= En_Config & ~en_q;
        end
    end

    logic        rep_act, rep_up;
    logic [31:0] rep_cnt;
    logic        do_step, step_up, rep_start, rep_clr, rep_reload, rep_dec;
    logic [2:0]  campo_d;

    always_comb begin
        state_d    = state_q;
        campo_d    = Campo;
        do_step    = 1'b0;
        step_up    = 1'b0;
        rep_start  = 1'b0;
        rep_clr    = 1'b0;
        rep_reload = 1'b0;
        rep_dec    = 1'b0;
        case (state_q)
            IDLE: begin
                rep_clr = 1'b1;
                if (en_edge_q) state_d = LOAD;
            end
            LOAD: begin
                rep_clr = 1'b1;
                campo_d = 3'd0;
                state_d = EDIT;
            end
            EDIT: begin
                if (!En_Config) begin
                    rep_clr = 1'b1;
                    state_d = IDLE;
                end else if (edge_q[4]) begin
                    rep_clr = 1'b1;
                    state_d = COMMIT;
                end else if (edge_q[3] || edge_q[2]) begin
                    do_step   = 1'b1;
                    step_up   = edge_q[3];
                    rep_start = 1'b1;
                end else if (edge_q[1]) begin
                    rep_clr = 1'b1;
                    campo_d = (Campo == 3'd5) ? 3'd0 : Campo + 3'd1;
                end else if (edge_q[0]) begin
                    rep_clr = 1'b1;
                    campo_d = (Campo == 3'd0) ? 3'd5 : Campo - 3'd1;
                end else if (rep_act) begin
                    if (!(rep_up ? Btn_Up : Btn_Down)) rep_clr = 1'b1;
                    else if (rep_cnt == 32'd0) begin
                        do_step    = 1'b1;
                        step_up    = rep_up;
                        rep_reload = 1'b1;
                    end else rep_dec = 1'b1;
                end
            end
            COMMIT: begin
                rep_clr = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    assign Editando = (state_q == EDIT);
    assign Listo    = (state_q == COMMIT);

    logic [6:0] maxd;
    logic [7:0] hora_step, hora_conv;
    assign maxd      = maxday(Mes, Ano);
    assign hora_step = mode_q ? step12(clk_hora[5:0], step_up) : step_bcd(clk_hora, step_up, 7'd0, 7'd23);
    assign hora_conv = doce_24 ? to12(clk_hora) : to24(clk_hora[5:0]);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            clk_seg  <= 8'h00;
            clk_min  <= 8'h00;
            clk_hora <= 8'h00;
            Dia      <= 8'h01;
            Mes      <= 8'h01;
            Ano      <= 8'h00;
            Campo    <= 3'd0;
            mode_q   <= doce_24;
            rep_act  <= 1'b0;
            rep_up   <= 1'b0;
            rep_cnt  <= '0;
        end else begin
            mode_q <= doce_24;
            Campo  <= campo_d;
            if (rep_clr) rep_act <= 1'b0;
            else if (rep_start) begin
                rep_act <= 1'b1;
                rep_up  <= step_up;
                rep_cnt <= 32'(REP_DLY - 1);
            end else if (rep_reload) rep_cnt <= 32'(REP_RATE - 1);
            else if (rep_dec) rep_cnt <= rep_cnt - 32'd1;

            if (state_q == LOAD) begin
                clk_seg  <= Seg_In;
                clk_min  <= Min_In;
                clk_hora <= Hora_In;
                Dia      <= Dia_In;
                Mes      <= Mes_In;
                Ano      <= Ano_In;
            end else if (state_q == EDIT) begin
                if (do_step) begin
                    case (Campo)
                        3'd0: clk_seg  <= step_bcd(clk_seg, step_up, 7'd0, 7'd59);
                        3'd1: clk_min  <= step_bcd(clk_min, step_up, 7'd0, 7'd59);
                        3'd2: clk_hora <= hora_step;
                        3'd3: Dia      <= step_bcd(Dia, step_up, 7'd1, maxd);
                        3'd4: Mes      <= step_bcd(Mes, step_up, 7'd1, 7'd12);
                        3'd5: Ano      <= step_bcd(Ano, step_up, 7'd0, 7'd99);
                        default: ;
                    endcase
                end
                // a month/year change is followed by a day clamp one cycle later
                if (!(do_step && Campo == 3'd3) && b2i(Dia) > maxd) Dia <= i2b(maxd);
                if (doce_24 != mode_q) clk_hora <= hora_conv;
            end
        end
    end
endmodule

// File: tb/tb_rtc_param_editor.sv
// Scoreboard bench: stimulus queues cycle-tagged expectations and commit snapshots;
// a negedge monitor pops and compares them against the DUT outputs.
module tb_rtc_param_editor;
    logic CLK = 1'b0, Reset = 1'b1, En_Config = 1'b0, doce_24 = 1'b0;
    logic Btn_Up = 1'b0, Btn_Down = 1'b0, Btn_Right = 1'b0, Btn_Left = 1'b0, Btn_Guardar = 1'b0;
    logic [7:0] Seg_In = 8'h00, Min_In = 8'h00, Hora_In = 8'h00, Dia_In = 8'h01, Mes_In = 8'h01, Ano_In = 8'h00;
    logic [7:0] clk_seg, clk_min, clk_hora, Dia, Mes, Ano;
    logic [2:0] Campo;
    logic       Editando, Listo;

    rtc_param_editor #(.REP_DLY(4), .REP_RATE(2)) dut (
        .CLK(CLK), .Reset(Reset), .En_Config(En_Config),
        .Btn_Up(Btn_Up), .Btn_Down(Btn_Down), .Btn_Right(Btn_Right), .Btn_Left(Btn_Left),
        .Btn_Guardar(Btn_Guardar), .doce_24(doce_24),
        .Seg_In(Seg_In), .Min_In(Min_In), .Hora_In(Hora_In), .Dia_In(Dia_In), .Mes_In(Mes_In), .Ano_In(Ano_In),
        .clk_seg(clk_seg), .clk_min(clk_min), .clk_hora(clk_hora), .Dia(Dia), .Mes(Mes), .Ano(Ano),
        .Campo(Campo), .Editando(Editando), .Listo(Listo)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {int cyc; string nm; int sig; logic [7:0] val;} exp_t;
    typedef struct {logic [7:0] seg, min, hora, dia, mes, ano;} snap_t;
    exp_t  q[$];
    snap_t cq[$];
    int n_tests = 0, n_fail = 0;

    localparam int S_SEG = 0, S_MIN = 1, S_HORA = 2, S_DIA = 3, S_MES = 4, S_ANO = 5,
                   S_CAMPO = 6, S_ED = 7, S_LISTO = 8;

    function automatic logic [7:0] obs(input int s);
        case (s)
            S_SEG:   return clk_seg;
            S_MIN:   return clk_min;
            S_HORA:  return clk_hora;
            S_DIA:   return Dia;
            S_MES:   return Mes;
            S_ANO:   return Ano;
            S_CAMPO: return {5'b0, Campo};
            S_ED:    return {7'b0, Editando};
            default: return {7'b0, Listo};
        endcase
    endfunction

    always @(negedge CLK) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            exp_t e;
            e = q[i];
            if (e.cyc == cyc) begin
                n_tests++;
                if (obs(e.sig) !== e.val) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got %h, want %h", e.nm, cyc, obs(e.sig), e.val);
                end
                q.delete(i);
            end else if (e.cyc < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: check cycle %0d passed unchecked", e.nm, e.cyc);
                q.delete(i);
            end
        end
        if (Listo === 1'b1) begin
            n_tests++;
            if (cq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected listo @cyc %0d", cyc);
            end else begin
                snap_t s;
                s = cq.pop_front();
                if ({clk_seg, clk_min, clk_hora, Dia, Mes, Ano} !== {s.seg, s.min, s.hora, s.dia, s.mes, s.ano}) begin
                    n_fail++;
                    $display("FAIL commit values: got %h %h %h %h %h %h, want %h %h %h %h %h %h",
                             clk_seg, clk_min, clk_hora, Dia, Mes, Ano, s.seg, s.min, s.hora, s.dia, s.mes, s.ano);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic exp_at(input int dly, input string nm, input int s, input logic [7:0] v);
        q.push_back('{cyc + dly, nm, s, v});
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: Btn_Guardar = v;
            1: Btn_Up      = v;
            2: Btn_Down    = v;
            3: Btn_Right   = v;
            default: Btn_Left = v;
        endcase
    endtask

    // one-cycle pulse; the resulting action is visible at the negedge this returns on
    task automatic press(input int b);
        set_btn(b, 1'b1);
        tick(1);
        set_btn(b, 1'b0);
        tick(1);
    endtask

    task automatic open_session(input logic [7:0] s, mi, h, d, me, a);
        Seg_In = s; Min_In = mi; Hora_In = h; Dia_In = d; Mes_In = me; Ano_In = a;
        En_Config = 1'b1;
        exp_at(2, "editando not yet", S_ED, 8'h00);
        exp_at(3, "editando after load", S_ED, 8'h01);
        exp_at(3, "load seg", S_SEG, s);
        exp_at(3, "load campo", S_CAMPO, 8'h00);
        tick(3);
    endtask

    task automatic close_session();
        En_Config = 1'b0;
        exp_at(1, "exit edit", S_ED, 8'h00);
        tick(2);
    endtask

    initial begin
        En_Config = 1'b1;
        tick(1);
        exp_at(1, "reset seg", S_SEG, 8'h00);
        exp_at(1, "reset hora", S_HORA, 8'h00);
        exp_at(1, "reset dia", S_DIA, 8'h01);
        exp_at(1, "reset mes", S_MES, 8'h01);
        exp_at(1, "reset campo", S_CAMPO, 8'h00);
        exp_at(1, "reset editando", S_ED, 8'h00);
        exp_at(1, "reset listo", S_LISTO, 8'h00);
        tick(2);
        Reset = 1'b0;
        exp_at(4, "en held through reset", S_ED, 8'h00);
        tick(5);
        En_Config = 1'b0;
        tick(2);

        // seconds, minutes and year wrap
        open_session(8'h58, 8'h59, 8'h00, 8'h15, 8'h06, 8'h99);
        exp_at(2, "seg up", S_SEG, 8'h59);        press(1);
        exp_at(2, "seg wrap up", S_SEG, 8'h00);   press(1);
        exp_at(2, "seg wrap down", S_SEG, 8'h59); press(2);
        exp_at(2, "campo right", S_CAMPO, 8'h01); press(3);
        exp_at(2, "min wrap up", S_MIN, 8'h00);   press(1);
        exp_at(2, "min wrap down", S_MIN, 8'h59); press(2);
        exp_at(2, "campo left", S_CAMPO, 8'h00);  press(4);
        exp_at(2, "campo left wrap", S_CAMPO, 8'h05); press(4);
        exp_at(2, "ano wrap up", S_ANO, 8'h00);   press(1);
        exp_at(2, "ano wrap down", S_ANO, 8'h99); press(2);
        exp_at(2, "campo right wrap", S_CAMPO, 8'h00); press(3);
        cq.push_back('{8'h59, 8'h59, 8'h00, 8'h15, 8'h06, 8'h99});
        exp_at(2, "listo high", S_LISTO, 8'h01);
        exp_at(3, "listo one cycle", S_LISTO, 8'h00);
        exp_at(3, "idle after commit", S_ED, 8'h00);
        exp_at(3, "seg held after commit", S_SEG, 8'h59);
        press(0);
        tick(2);
        close_session();

        // day clamp on month change, non-leap then leap year
        open_session(8'h00, 8'h00, 8'h00, 8'h31, 8'h01, 8'h23);
        press(4);
        exp_at(2, "campo mes", S_CAMPO, 8'h04); press(4);
        exp_at(2, "mes up", S_MES, 8'h02);
        exp_at(2, "dia before clamp", S_DIA, 8'h31);
        exp_at(3, "dia clamp 28", S_DIA, 8'h28);
        press(1);
        tick(1);
        close_session();
        open_session(8'h00, 8'h00, 8'h00, 8'h31, 8'h01, 8'h24);
        press(4);
        press(4);
        exp_at(3, "dia clamp 29 leap", S_DIA, 8'h29);
        press(1);
        tick(1);
        close_session();

        // 12-hour stepping and mode conversion
        doce_24 = 1'b1;
        open_session(8'h00, 8'h00, 8'h51, 8'h01, 8'h01, 8'h00);
        press(3);
        exp_at(2, "campo hora", S_CAMPO, 8'h02);  press(3);
        exp_at(2, "11am up 12pm", S_HORA, 8'h72); press(1);
        exp_at(2, "12pm up 01pm", S_HORA, 8'h61); press(1);
        exp_at(2, "01pm down 12pm", S_HORA, 8'h72); press(2);
        exp_at(2, "12pm up again", S_HORA, 8'h61); press(1);
        doce_24 = 1'b0;
        exp_at(1, "01pm to 24h", S_HORA, 8'h13);
        tick(2);
        Btn_Guardar = 1'b1;
        Btn_Up      = 1'b1;
        cq.push_back('{8'h00, 8'h00, 8'h13, 8'h01, 8'h01, 8'h00});
        exp_at(2, "guardar+up commits", S_LISTO, 8'h01);
        exp_at(3, "up ignored on commit", S_HORA, 8'h13);
        tick(1);
        Btn_Guardar = 1'b0;
        Btn_Up      = 1'b0;
        tick(3);
        close_session();

        // auto-repeat: steps at edge+1, +5, +7, +9, then release
        open_session(8'h10, 8'h00, 8'h00, 8'h05, 8'h07, 8'h00);
        Btn_Up = 1'b1;
        exp_at(2, "rep edge step", S_SEG, 8'h11);
        exp_at(5, "rep waiting", S_SEG, 8'h11);
        exp_at(6, "rep first", S_SEG, 8'h12);
        exp_at(7, "rep between", S_SEG, 8'h12);
        exp_at(8, "rep second", S_SEG, 8'h13);
        exp_at(10, "rep third", S_SEG, 8'h14);
        exp_at(12, "rep stopped", S_SEG, 8'h14);
        exp_at(14, "rep still stopped", S_SEG, 8'h14);
        tick(10);
        Btn_Up = 1'b0;
        tick(5);

        // reset while in COMMIT
        cq.push_back('{8'h14, 8'h00, 8'h00, 8'h05, 8'h07, 8'h00});
        Btn_Guardar = 1'b1;
        exp_at(2, "listo before reset", S_LISTO, 8'h01);
        exp_at(3, "listo after reset", S_LISTO, 8'h00);
        exp_at(3, "reset in commit seg", S_SEG, 8'h00);
        exp_at(3, "reset in commit dia", S_DIA, 8'h01);
        exp_at(3, "reset in commit mes", S_MES, 8'h01);
        tick(1);
        Btn_Guardar = 1'b0;
        tick(1);
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        En_Config = 1'b0;
        tick(3);

        foreach (q[i]) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: never checked", q[i].nm);
        end
        if (cq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL listo count: got %0d missing pulses, want 0", cq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
